lsu_align: RTL and testbench
============================

# lsu_align

Load/store unit for the RV32 core: accepts one load or store per request from the execute stage, runs a request/grant/response handshake with data memory, and produces byte-aligned, sign- or zero-extended load data. That data feeds the load-data input of the writeback result-select multiplexer. Misaligned or illegal-size accesses are reported without touching memory.

## Interface
- AW, 32, byte-address width of core and memory address ports
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- lsu_req  in  1  access request; held high by the core until the cycle lsu_done is seen
- lsu_we  in  1  1 = store, 0 = load
- lsu_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- lsu_addr  in  AW  byte address
- lsu_wdata  in  32  store data, right-aligned
- lsu_stall  out  1  hold the pipeline
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  valid with lsu_done; 1 = misaligned or illegal size, no memory access made
- lsu_rdata  out  32  extended load data for the writeback select; held until the next load completes
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  4  byte enables
- mem_addr  out  AW  word-aligned address (bits [1:0] = 00)
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: lsu_req is sampled here only. Legal access: latch we, size, addr[1:0]; drive mem_* registers; go to REQ. Illegal access: set lsu_err; go to DONE with no mem_req.
- Illegal access: halfword with addr[0]=1; word with addr[1:0]≠00; size 011, 110 or 111; store with size 100 or 101.
- REQ: mem_req=1; mem_we, mem_be, mem_addr and mem_wdata are held stable until mem_gnt=1. On grant, a store goes to DONE and a load goes to RESP. mem_rvalid is ignored in REQ.
- RESP: wait for mem_rvalid. When it arrives, register lsu_rdata and go to DONE.
- DONE: lsu_done=1 for one cycle, then go to IDLE. Any lsu_req seen in DONE belongs to the completed access and is ignored.
- Byte enables:
  - B: 0001 << addr[1:0]
  - H: 0011 << {addr[1],1'b0}
  - W: 1111
- Store data:
  - B: byte replicated ×4
  - H: halfword replicated ×2
  - W: unchanged
- Load data: shift mem_rdata right by 8·addr[1:0].
  - B/H: sign-extend bit 7 / bit 15
  - BU/HU: zero-extend
  - W: unchanged
- lsu_stall = lsu_req & (state ≠ DONE). This is combinational.
- lsu_err is cleared on leaving DONE. A load that ends with lsu_err=1 does not update lsu_rdata.

## Timing
- Reset (asynchronous, rst_n=0):
  - state → IDLE
  - mem_req, mem_we, lsu_done, lsu_err → 0
  - mem_be → 0000
  - mem_addr, mem_wdata, lsu_rdata → 0
- mem_req rises the cycle after acceptance in IDLE. It never rises in the same cycle.
- Minimum store latency, counted from the acceptance edge: grant in the first REQ cycle, lsu_done 2 cycles later.
- Minimum load latency: grant in the first REQ cycle, mem_rvalid in the first RESP cycle, lsu_done 3 cycles later.
- Illegal access: lsu_done 1 cycle after acceptance.
- Back-to-back accesses pass through IDLE, so each access costs at least one extra cycle.
- Grant wait and rvalid wait are both unbounded.
- mem_gnt and mem_rvalid high in the same REQ cycle: the grant is taken, the rvalid is ignored, and the FSM waits for a later rvalid.
- Reset asserted mid-access drops mem_req asynchronously. A stale mem_rvalid arriving after reset, while in IDLE, is ignored.

## Test plan
- LW, addr 0x100, mem_rdata 0xDEADBEEF, gnt and rvalid with zero wait → mem_addr=0x100, mem_be=1111, lsu_rdata=0xDEADBEEF, lsu_done 3 cycles after acceptance.
- LB/LBU, addr 0x103, mem_rdata 0x80FF1234 → LB gives lsu_rdata=0xFFFFFF80; LBU gives 0x00000080.
- SH, addr 0x0A, wdata 0x0000ABCD, gnt delayed 4 cycles → mem_addr=0x08, mem_be=1100, mem_wdata=0xABCDABCD, all stable for 5 REQ cycles, lsu_done 6 cycles after acceptance.
- LW at 0x102 and SH at 0x101 → lsu_err=1 with lsu_done 1 cycle after acceptance, mem_req never asserted, lsu_rdata unchanged.
- Load with rvalid delayed 3 cycles, rst_n pulsed low during RESP, then stale rvalid delivered → all outputs at reset values, state IDLE, no lsu_done.
- Two SB accesses back-to-back at 0x201 and 0x202, wdata 0x55 → mem_be 0010 then 0100, mem_wdata=0x55555555 for both, two separate lsu_done pulses.

Source files
------------

// File: rtl/lsu_align.sv
// RV32 load/store unit: request/grant/response handshake with data memory,
// store lane replication, and load alignment with sign/zero extension.
module lsu_align #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lsu_req,
  input  logic          lsu_we,
  input  logic [2:0]    lsu_size,
  input  logic [AW-1:0] lsu_addr,
  input  logic [31:0]   lsu_wdata,
  output logic          lsu_stall,
  output logic          lsu_done,
  output logic          lsu_err,
  output logic [31:0]   lsu_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  // state | meaning
  // IDLE  | sample lsu_req, decode, launch memory request or flag error
  // REQ   | mem_req high, wait for mem_gnt
  // RESP  | load granted, wait for mem_rvalid
  // DONE  | one-cycle lsu_done pulse, lsu_err valid
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   lsu_rdata_q, lsu_rdata_d;
  logic          lsu_done_q, lsu_done_d;
  logic          lsu_err_q, lsu_err_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;

  logic          illegal;
  logic [3:0]    be_req;
  logic [31:0]   wdata_req;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  always_comb begin
    illegal = 1'b0;
    unique case (lsu_size)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = lsu_addr[0];
      3'b010:  illegal = |lsu_addr[1:0];
      3'b100:  illegal = lsu_we;
      3'b101:  illegal = lsu_we | lsu_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    be_req    = 4'b1111;
    wdata_req = lsu_wdata;
    unique case (lsu_size[1:0])
      2'b00: begin
        be_req    = 4'b0001 << lsu_addr[1:0];
        wdata_req = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        be_req    = 4'b0011 << {lsu_addr[1], 1'b0};
        wdata_req = {2{lsu_wdata[15:0]}};
      end
      default: begin
        be_req    = 4'b1111;
        wdata_req = lsu_wdata;
      end
    endcase
  end

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    unique case (size_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lsu_rdata_d = lsu_rdata_q;
    lsu_done_d  = 1'b0;
    lsu_err_d   = lsu_err_q;
    size_d      = size_q;
    off_d       = off_q;

    unique case (state_q)
      IDLE: begin
        if (lsu_req) begin
          if (illegal) begin
            lsu_err_d  = 1'b1;
            lsu_done_d = 1'b1;
            state_d    = DONE;
          end else begin
            size_d      = lsu_size;
            off_d       = lsu_addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = lsu_we;
            mem_be_d    = be_req;
            mem_addr_d  = {lsu_addr[AW-1:2], 2'b00};
            mem_wdata_d = wdata_req;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        // rvalid in the grant cycle belongs to nothing we issued; only RESP listens
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            lsu_done_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          lsu_rdata_d = load_ext;
          lsu_done_d  = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        lsu_err_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      lsu_rdata_q <= 32'h0;
      lsu_done_q  <= 1'b0;
      lsu_err_q   <= 1'b0;
      size_q      <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_done_q  <= lsu_done_d;
      lsu_err_q   <= lsu_err_d;
      size_q      <= size_d;
      off_q       <= off_d;
    end
  end

  assign lsu_stall = lsu_req & (state_q != DONE);
  assign lsu_done  = lsu_done_q;
  assign lsu_err   = lsu_err_q;
  assign lsu_rdata = lsu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed vector table, back-to-back and
// reset corner sequences, and random accesses against a behavioural model.
module tb_lsu_align;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lsu_req = 1'b0;
  logic          lsu_we = 1'b0;
  logic [2:0]    lsu_size = 3'b000;
  logic [AW-1:0] lsu_addr = '0;
  logic [31:0]   lsu_wdata = 32'h0;
  logic          lsu_stall, lsu_done, lsu_err;
  logic [31:0]   lsu_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = 32'h0;

  lsu_align #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    bit          both;
    bit          exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rdata_ref = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit m_illegal(bit we, logic [2:0] size, logic [31:0] addr);
    int nbytes;
    if (size == 3'd3 || size >= 3'd6) return 1'b1;
    if (we && size >= 3'd4) return 1'b1;
    nbytes = 1 << size[1:0];
    return (addr % nbytes) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] size, logic [31:0] addr);
    int nbytes = 1 << size[1:0];
    return 4'(((1 << nbytes) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] size, logic [31:0] wdata);
    int nbytes = 1 << size[1:0];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(logic [2:0] size, logic [31:0] addr, logic [31:0] word);
    int nbits = 8 * (1 << size[1:0]);
    longint v = longint'(word >> (8 * (addr % 4)));
    if (nbits < 32) begin
      v = v % (longint'(1) << nbits);
      if (size < 3'd4 && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    end
    return 32'(v);
  endfunction

  task automatic run_access(input vec_t v, input bit keep, input string tag);
    bit done = 0, granted = 0, bad_hold = 0;
    int req_cnt = 0, resp_cnt = 0, lat = -1, exp_req;
    @(negedge clk);
    chk({tag, " idle"}, 32'({mem_req, lsu_done}), 32'h0);
    lsu_req = 1'b1; lsu_we = v.we; lsu_size = v.size; lsu_addr = v.addr; lsu_wdata = v.wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1 chk({tag, " stall"}, 32'(lsu_stall), 32'h1);
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0BAD_F00D;
      if (lsu_done) begin
        done = 1; lat = c;
      end else begin
        if (lsu_stall !== 1'b1) bad_hold = 1;
        if (mem_req) begin
          req_cnt++;
          if (granted || mem_be !== v.exp_be || mem_addr !== v.exp_addr || mem_we !== v.we ||
              (v.we && mem_wdata !== v.exp_wdata)) bad_hold = 1;
          if (req_cnt == v.gdly + 1) begin
            mem_gnt = 1'b1; granted = 1;
            if (v.both) mem_rvalid = 1'b1;
          end
        end else if (granted && !v.we) begin
          resp_cnt++;
          if (resp_cnt == v.rdly + 1) begin
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
          end
        end
      end
    end
    exp_req = v.exp_err ? 0 : v.gdly + 1;
    chk({tag, " done_seen"}, 32'(done), 32'h1);
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " err"}, 32'(lsu_err), 32'(v.exp_err));
    chk({tag, " rdata"}, lsu_rdata, v.exp_rdata);
    chk({tag, " req_cycles"}, 32'(req_cnt), 32'(exp_req));
    chk({tag, " hold"}, 32'(bad_hold), 32'h0);
    chk({tag, " stall_done"}, 32'(lsu_stall), 32'h0);
    if (!keep) lsu_req = 1'b0;
    rdata_ref = v.exp_rdata;
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    //        we size   addr          wdata         rdata         g  r  both err be       addr          wdata         rdata         lat
    tbl[0]  = '{0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 3};
    tbl[1]  = '{0, 3'd0, 32'h103, 32'h0,        32'h80FF1234, 1, 2, 0, 0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 6};
    tbl[2]  = '{0, 3'd4, 32'h103, 32'h0,        32'h80FF1234, 0, 0, 0, 0, 4'b1000, 32'h100, 32'h0,        32'h00000080, 3};
    tbl[3]  = '{1, 3'd1, 32'h00A, 32'h0000ABCD, 32'h0,        4, 0, 0, 0, 4'b1100, 32'h008, 32'hABCDABCD, 32'h00000080, 6};
    tbl[4]  = '{0, 3'd2, 32'h102, 32'h0,        32'h11111111, 0, 0, 0, 1, 4'b0000, 32'h0,   32'h0,        32'h00000080, 1};
    tbl[5]  = '{1, 3'd1, 32'h101, 32'h1234,     32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,   32'h0,        32'h00000080, 1};
    tbl[6]  = '{0, 3'd1, 32'h202, 32'h0,        32'h80017FFF, 0, 0, 1, 0, 4'b1100, 32'h200, 32'h0,        32'hFFFF8001, 3};
    tbl[7]  = '{0, 3'd5, 32'h202, 32'h0,        32'h80017FFF, 2, 1, 0, 0, 4'b1100, 32'h200, 32'h0,        32'h00008001, 6};
    tbl[8]  = '{1, 3'd0, 32'h003, 32'h12345678, 32'h0,        0, 0, 0, 0, 4'b1000, 32'h000, 32'h78787878, 32'h00008001, 2};
    tbl[9]  = '{1, 3'd2, 32'h010, 32'hA5A50F0F, 32'h0,        1, 0, 0, 0, 4'b1111, 32'h010, 32'hA5A50F0F, 32'h00008001, 3};
    tbl[10] = '{1, 3'd4, 32'h020, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,   32'h0,        32'h00008001, 1};
    tbl[11] = '{0, 3'd3, 32'h000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,   32'h0,        32'h00008001, 1};
    tbl[12] = '{0, 3'd7, 32'h000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,   32'h0,        32'h00008001, 1};
    tbl[13] = '{0, 3'd1, 32'h000, 32'h0,        32'h1234F00F, 0, 3, 1, 0, 4'b0011, 32'h000, 32'h0,        32'hFFFFF00F, 6};

    repeat (3) @(negedge clk);
    chk("rst ctrl", 32'({mem_req, mem_we, lsu_done, lsu_err, mem_be}), 32'h0);
    chk("rst addr", mem_addr, 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    chk("rst rdata", lsu_rdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_access(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // back-to-back byte stores with lsu_req held high through DONE
    rv = '{1, 3'd0, 32'h201, 32'h55, 32'h0, 0, 0, 0, 0, 4'b0010, 32'h200, 32'h55555555, rdata_ref, 2};
    run_access(rv, 1'b1, "b2b_a");
    rv = '{1, 3'd0, 32'h202, 32'h55, 32'h0, 0, 0, 0, 0, 4'b0100, 32'h200, 32'h55555555, rdata_ref, 2};
    run_access(rv, 1'b0, "b2b_b");

    for (int i = 0; i < 60; i++) begin
      rv.we    = 1'($urandom_range(0, 1));
      rv.size  = 3'($urandom_range(0, 7));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.gdly  = $urandom_range(0, 3);
      rv.rdly  = $urandom_range(0, 3);
      rv.both  = 1'($urandom_range(0, 1));
      rv.exp_err   = m_illegal(rv.we, rv.size, rv.addr);
      rv.exp_be    = rv.exp_err ? 4'b0000 : m_be(rv.size, rv.addr);
      rv.exp_addr  = rv.addr & ~32'h3;
      rv.exp_wdata = rv.exp_err ? 32'h0 : m_wdata(rv.size, rv.wdata);
      rv.exp_rdata = (!rv.we && !rv.exp_err) ? m_rdata(rv.size, rv.addr, rv.rdata) : rdata_ref;
      rv.exp_lat   = rv.exp_err ? 1 : (rv.we ? rv.gdly + 2 : rv.gdly + rv.rdly + 3);
      run_access(rv, 1'b0, $sformatf("rnd%0d", i));
    end

    // reset during RESP, then a stale rvalid while idle
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h300;
    @(negedge clk);
    chk("rst_seq req", 32'(mem_req), 32'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst ctrl", 32'({mem_req, mem_we, lsu_done, lsu_err, mem_be}), 32'h0);
    chk("midrst addr", mem_addr, 32'h0);
    chk("midrst wdata", mem_wdata, 32'h0);
    chk("midrst rdata", lsu_rdata, 32'h0);
    lsu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEBABE;
    @(negedge clk);
    mem_rvalid = 1'b0;
    begin
      bit stray = 0;
      repeat (5) begin
        @(negedge clk);
        if (lsu_done || mem_req || lsu_rdata !== 32'h0) stray = 1;
      end
      chk("stale rvalid", 32'(stray), 32'h0);
    end
    rdata_ref = 32'h0;
    rv = '{0, 3'd2, 32'h400, 32'h0, 32'h01234567, 0, 0, 0, 0, 4'b1111, 32'h400, 32'h0, 32'h01234567, 3};
    run_access(rv, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
